// File: rtl/rll_key_loader.sv
// Key-load sequencer for a random-logic-locked netlist: assembles a byte-streamed key in a shadow
// register and commits it atomically. Optional trailing XOR checksum beat under RLL_KEY_CHECKSUM_EN.
module rll_key_loader #(
  parameter int KEY_WIDTH  = 32,
  parameter int BEAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  zeroize,
  input  logic                  in_valid,
  input  logic [BEAT_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_applied,
  output logic                  busy,
  output logic                  error
);

  localparam int NBEATS = KEY_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_COMMIT = 3'd3;
`ifdef RLL_KEY_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_FAIL   = 3'd4;
`endif

  logic [2:0]           state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [KEY_WIDTH-1:0] shadow;
  logic                 accept;

  // Decoded from the state register only, so in_ready never depends on in_valid.
`ifdef RLL_KEY_CHECKSUM_EN
  logic [BEAT_WIDTH-1:0] chk;
  assign in_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign busy     = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_COMMIT);
`else
  assign in_ready = (state == ST_LOAD);
  assign busy     = (state == ST_LOAD) || (state == ST_COMMIT);
  assign error    = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  // NOTE: every register here is written with <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the shadow holds key material, so it is explicitly cleared on reset and zeroize.
    if (!rst_n) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      shadow      <= '0;
      key_out     <= '0;
      key_applied <= 1'b0;
`ifdef RLL_KEY_CHECKSUM_EN
      chk         <= '0;
      error       <= 1'b0;
`endif
    end else if (zeroize) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      shadow      <= '0;
      key_out     <= '0;
      key_applied <= 1'b0;
`ifdef RLL_KEY_CHECKSUM_EN
      chk         <= '0;
      error       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            beat_cnt <= '0;
            shadow   <= '0;
`ifdef RLL_KEY_CHECKSUM_EN
            chk      <= '0;
            error    <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
            for (int k = 0; k < NBEATS; k++) begin
              if (beat_cnt == CNT_W'(k)) shadow[k*BEAT_WIDTH +: BEAT_WIDTH] <= in_data;
            end
            beat_cnt <= beat_cnt + 1'b1;
`ifdef RLL_KEY_CHECKSUM_EN
            chk <= chk ^ in_data;
            if (beat_cnt == LAST_BEAT) state <= ST_CHECK;
`else
            if (beat_cnt == LAST_BEAT) state <= ST_COMMIT;
`endif
          end
        end
`ifdef RLL_KEY_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) state <= (in_data == chk) ? ST_COMMIT : ST_FAIL;
        end
        ST_FAIL: begin
          if (start) begin
            state    <= ST_LOAD;
            beat_cnt <= '0;
            shadow   <= '0;
            chk      <= '0;
            error    <= 1'b0;
          end else begin
            key_out     <= '0;
            key_applied <= 1'b0;
            error       <= 1'b1;
          end
        end
`endif
        ST_COMMIT: begin
          // The only place key_out takes shadow contents: one atomic update per good load.
          key_out     <= shadow;
          key_applied <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed testbench for rll_key_loader; covers both builds depending on RLL_KEY_CHECKSUM_EN.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        zeroize;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] key_out;
  logic        key_applied;
  logic        busy;
  logic        error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rll_key_loader #(.KEY_WIDTH(32), .BEAT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .zeroize(zeroize),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .key_out(key_out), .key_applied(key_applied), .busy(busy), .error(error)
  );

  // Advance one rising edge, then settle before sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; zeroize = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    total_cnt++;
    if (key_out !== 32'h0) $display("FAIL reset_key_out: got %h expected %h", key_out, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if ({key_applied, in_ready, busy, error} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected %b", {key_applied, in_ready, busy, error}, 4'b0000);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({in_ready, busy} !== 2'b00) $display("FAIL idle_flags: got %b expected %b", {in_ready, busy}, 2'b00);
    else pass_cnt++;
  endtask

  // Full load of key with optional idle gaps before each beat; key_out must hold old_key until commit.
  task automatic do_load(input logic [31:0] key, input int gap, input logic [31:0] old_key,
                         input logic start_mid, input string name);
    logic [7:0] sum;
    sum = key[7:0] ^ key[15:8] ^ key[23:16] ^ key[31:24];
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({in_ready, busy} !== 2'b11) $display("FAIL %s_start: got %b expected %b", name, {in_ready, busy}, 2'b11);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (key_out !== old_key) $display("FAIL %s_gap%0d: got %h expected %h", name, k, key_out, old_key);
        else pass_cnt++;
      end
      in_valid = 1'b1;
      in_data  = key[k*8 +: 8];
      start    = start_mid && (k == 1);
      step();
      in_valid = 1'b0;
      start    = 1'b0;
      total_cnt++;
      if (key_out !== old_key) $display("FAIL %s_beat%0d: got %h expected %h", name, k, key_out, old_key);
      else pass_cnt++;
    end
`ifdef RLL_KEY_CHECKSUM_EN
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s_check_ready: got %b expected %b", name, in_ready, 1'b1);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = sum;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (key_out !== old_key) $display("FAIL %s_chk_beat: got %h expected %h", name, key_out, old_key);
    else pass_cnt++;
`endif
    total_cnt++;
    if ({in_ready, busy} !== 2'b01) $display("FAIL %s_commit_state: got %b expected %b", name, {in_ready, busy}, 2'b01);
    else pass_cnt++;
    step();
    total_cnt++;
    if (key_out !== key) $display("FAIL %s_key_out: got %h expected %h", name, key_out, key);
    else pass_cnt++;
    total_cnt++;
    if ({key_applied, busy, in_ready, error} !== 4'b1000)
      $display("FAIL %s_done_flags: got %b expected %b", name, {key_applied, busy, in_ready, error}, 4'b1000);
    else pass_cnt++;
  endtask

  task automatic test_first_load();
    // start pulsed alongside beat 1 must be ignored.
    do_load(32'hA5C31E7F, 0, 32'h0, 1'b1, "first_load");
  endtask

  task automatic test_reload_gaps();
    do_load(32'h12345678, 2, 32'hA5C31E7F, 1'b0, "reload");
  endtask

  task automatic test_zeroize();
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    zeroize = 1'b1; in_data = 8'h33; step();
    zeroize = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (key_out !== 32'h0) $display("FAIL zeroize_key_out: got %h expected %h", key_out, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if ({key_applied, in_ready, busy, error} !== 4'b0000)
      $display("FAIL zeroize_flags: got %b expected %b", {key_applied, in_ready, busy, error}, 4'b0000);
    else pass_cnt++;
    do_load(32'hDEADBEEF, 0, 32'h0, 1'b0, "post_zeroize");
  endtask

`ifdef RLL_KEY_CHECKSUM_EN
  task automatic test_bad_checksum();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      case (k)
        0: in_data = 8'h7F;
        1: in_data = 8'h1E;
        2: in_data = 8'hC3;
        default: in_data = 8'hA5;
      endcase
      step();
    end
    in_data = 8'h08; step();
    in_valid = 1'b0;
    total_cnt++;
    if (key_out !== 32'hDEADBEEF) $display("FAIL bad_chk_hold: got %h expected %h", key_out, 32'hDEADBEEF);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({error, key_applied, key_out} !== {2'b10, 32'h0})
      $display("FAIL bad_chk_fail: got %b/%b/%h expected 1/0/00000000", error, key_applied, key_out);
    else pass_cnt++;
    step(); step(); step();
    total_cnt++;
    if ({error, in_ready, busy} !== 3'b100)
      $display("FAIL fail_sticky: got %b expected %b", {error, in_ready, busy}, 3'b100);
    else pass_cnt++;
    start = 1'b1; step(); start = 1'b0;
    total_cnt++;
    if ({error, in_ready} !== 2'b01) $display("FAIL fail_restart: got %b expected %b", {error, in_ready}, 2'b01);
    else pass_cnt++;
    zeroize = 1'b1; step(); zeroize = 1'b0;
    total_cnt++;
    if ({in_ready, busy} !== 2'b00) $display("FAIL fail_zeroize: got %b expected %b", {in_ready, busy}, 2'b00);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_load();
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; step();
    in_valid = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    total_cnt++;
    if ({key_out, key_applied, busy, in_ready} !== {32'h0, 3'b000})
      $display("FAIL reset_mid_load: got %h/%b%b%b expected 00000000/000", key_out, key_applied, busy, in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_reload_gaps();
    test_zeroize();
`ifdef RLL_KEY_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
